// File: rtl/jtframe_scan2x_fx.sv
// jtframe_scan2x_fx
// Line-doubling scan converter with optional scanline and blend effects.
// The native pixel stream is written into one bank of a ping-pong line buffer.
// The last completed line is read out of the other bank twice, at double rate.
// Line length and HS width are measured at run time.
//
// Parameters
//   DW    pixel width, three equal channels, MSB channel first (R,G,B)
//   HLEN  line-buffer depth per bank (maximum pixels per line)
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   base_cen     native pixel enable; base_pxl and HS are sampled on it
//   basex2_cen   double-rate enable (every base_cen plus one midway)
//   mode         0 plain, 1 scanline 75 %, 2 scanline 50 %, 3 horizontal blend
//   x2_pxl       doubled pixel stream (registered)
//   x2_HS        doubled horizontal sync (registered)
//   ovf          sticky: a line had more than HLEN pixels
module jtframe_scan2x_fx #(
    parameter int DW   = 12,
    parameter int HLEN = 512
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          base_cen,
    input  logic          basex2_cen,
    input  logic [DW-1:0] base_pxl,
    input  logic          HS,
    input  logic [1:0]    mode,
    output logic [DW-1:0] x2_pxl,
    output logic          x2_HS,
    output logic          ovf
);

    localparam int CW = DW / 3;
    localparam int AW = $clog2(HLEN);

    typedef enum logic [1:0] {
        FX_PLAIN  = 2'd0,
        FX_SCAN75 = 2'd1,
        FX_SCAN50 = 2'd2,
        FX_BLEND  = 2'd3
    } fx_e;

    // Bank select is the MSB of the buffer index.
    logic [DW-1:0] mem [0:(1<<(AW+1))-1];

    logic          wbank, rbank, hs_l, wfull;
    logic [AW-1:0] wraddr, rdaddr, hs_cnt, hsw;
    logic [AW:0]   len;
    fx_e           mode_l;
    logic          half, half_d, first_d;
    logic [DW-1:0] rd_data, prev, fx_pxl;
    logic          hs_rise;
    logic [AW:0]   wr_idx, rd_idx;

    assign hs_rise = base_cen & HS & ~hs_l;
    // The pixel that carries the HS rise already belongs to the new bank.
    assign wr_idx  = hs_rise ? {~wbank, {AW{1'b0}}} : {wbank, wraddr};
    assign rd_idx  = {rbank, rdaddr};

    // NOTE: the line buffer has no reset; clearing it would block RAM inference, and stale data on the first line after reset is harmless.
    always_ff @(posedge clk) begin
        if (base_cen)   mem[wr_idx] <= base_pxl;
        if (basex2_cen) rd_data     <= mem[rd_idx];
    end

    // Write side: address counter, bank swap, line length and HS width.
    // NOTE: all state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank  <= 1'b0;
            rbank  <= 1'b1;
            wraddr <= '0;
            wfull  <= 1'b0;
            len    <= (AW+1)'(HLEN);
            mode_l <= FX_PLAIN;
            ovf    <= 1'b0;
            hs_l   <= 1'b0;
            hs_cnt <= '0;
            hsw    <= '0;
        end else if (base_cen) begin
            hs_l <= HS;
            if (hs_rise) begin
                // A rise with nothing written keeps the previous length.
                if (wraddr != '0) len <= {1'b0, wraddr};
                rbank  <= wbank;
                wbank  <= ~wbank;
                wraddr <= AW'(1);
                wfull  <= 1'b0;
                mode_l <= fx_e'(mode);
            end else if (wraddr == AW'(HLEN-1)) begin
                // Last cell: the first write fills it, any further write overflows.
                if (wfull) ovf <= 1'b1;
                wfull <= 1'b1;
            end else begin
                wraddr <= wraddr + 1'b1;
            end

            if (HS) begin
                if (!hs_l)                         hs_cnt <= AW'(1);
                else if (hs_cnt != AW'(HLEN-1))    hs_cnt <= hs_cnt + 1'b1;
            end else if (hs_l) begin
                hsw <= hs_cnt;
            end
        end
    end

    // Per-channel effect. p is the previous raw pixel, already zeroed at line start.
    function automatic logic [CW-1:0] fx_chan(input fx_e m, input logic h,
                                              input logic [CW-1:0] c,
                                              input logic [CW-1:0] p);
        logic [CW:0] sum;
        sum = {1'b0, c} + {1'b0, p};
        case (m)
            FX_SCAN75: fx_chan = h ? c - (c >> 2) : c;
            FX_SCAN50: fx_chan = h ? (c >> 1) : c;
            FX_BLEND:  fx_chan = sum[CW:1];
            default:   fx_chan = c;
        endcase
    endfunction

    // NOTE: fx_pxl is assigned a default first so no path through this block can infer a latch.
    always_comb begin
        fx_pxl = rd_data;
        for (int i = 0; i < 3; i++) begin
            fx_pxl[i*CW +: CW] = fx_chan(mode_l, half_d, rd_data[i*CW +: CW],
                                         first_d ? {CW{1'b0}} : prev[i*CW +: CW]);
        end
    end

    // Read side and output stage. half_d/first_d travel with the fetched pixel
    // so the effect matches the half the pixel was read in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdaddr  <= '0;
            half    <= 1'b0;
            half_d  <= 1'b0;
            first_d <= 1'b0;
            prev    <= '0;
            x2_pxl  <= '0;
            x2_HS   <= 1'b0;
        end else if (basex2_cen) begin
            half_d  <= half;
            first_d <= (rdaddr == '0);
            x2_HS   <= (rdaddr < hsw);
            x2_pxl  <= fx_pxl;
            prev    <= rd_data;
            if (hs_rise) begin
                rdaddr <= '0;
                half   <= 1'b0;
            end else if ({1'b0, rdaddr} == len - 1'b1) begin
                rdaddr <= '0;
                half   <= ~half;
            end else begin
                rdaddr <= rdaddr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_scan2x_fx.sv
// Testbench for jtframe_scan2x_fx: directed lines with hand-derived expectations.
// Timing: base_cen every 4 clocks, basex2_cen every 2 clocks. One output sample
// is taken after every basex2_cen edge. Sample j of a line (j = 0 at its HS-rise
// tick) carries stored pixel (j-2) mod len of the previous line.
module tb_jtframe_scan2x_fx;

    localparam int DW   = 12;
    localparam int CW   = 4;
    localparam int HLEN = 512;
    localparam int NPX  = 384;
    localparam int HSW  = 32;

    typedef enum int {PX_INDEX, PX_WHITE, PX_ALT} pat_e;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          base_cen, basex2_cen, HS;
    logic [DW-1:0] base_pxl;
    logic [1:0]    mode;
    logic [DW-1:0] x2_pxl;
    logic          x2_HS, ovf;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] out_q[$];
    logic          hs_q[$];
    int            st[16];

    always #5 clk = ~clk;

    jtframe_scan2x_fx #(.DW(DW), .HLEN(HLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .base_cen   (base_cen),
        .basex2_cen (basex2_cen),
        .base_pxl   (base_pxl),
        .HS         (HS),
        .mode       (mode),
        .x2_pxl     (x2_pxl),
        .x2_HS      (x2_HS),
        .ovf        (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; starts and ends on a falling edge.
    task automatic cyc(input logic b, input logic b2, input logic [DW-1:0] px, input logic h);
        base_cen   = b;
        basex2_cen = b2;
        base_pxl   = px;
        HS         = h;
        @(posedge clk);
        @(negedge clk);
        if (b2) begin
            out_q.push_back(x2_pxl);
            hs_q.push_back(x2_HS);
        end
    endtask

    task automatic pixel(input logic [DW-1:0] px, input logic h);
        cyc(1'b1, 1'b1, px, h);
        cyc(1'b0, 1'b0, px, h);
        cyc(1'b0, 1'b1, px, h);
        cyc(1'b0, 1'b0, px, h);
    endtask

    function automatic logic [DW-1:0] pat(input pat_e k, input int i);
        case (k)
            PX_INDEX: return DW'(i);
            PX_WHITE: return 12'hFFF;
            default:  return i[0] ? 12'hFFF : 12'h000;
        endcase
    endfunction

    function automatic int chan_fx(input int m, input bit h, input int c, input int p);
        case (m)
            1:       return h ? c - c / 4 : c;
            2:       return h ? c / 2 : c;
            3:       return (c + p) / 2;
            default: return c;
        endcase
    endfunction

    // Expected sample j of a line that plays back a stored line of pattern k.
    function automatic logic [DW-1:0] expect_px(input pat_e k, input int j, input int m, input int len);
        int a;
        bit h;
        logic [DW-1:0] cv, pv, r;
        a  = (j - 2) % len;
        h  = ((j - 2) >= len);
        cv = pat(k, a);
        pv = (a == 0) ? '0 : pat(k, a - 1);
        r  = '0;
        for (int ch = 0; ch < 3; ch++) begin
            int c, p;
            c = int'((cv >> (CW*ch)) & 12'h00F);
            p = int'((pv >> (CW*ch)) & 12'h00F);
            r = r | DW'(chan_fx(m, h, c, p) << (CW*ch));
        end
        return r;
    endfunction

    task automatic send_line(input pat_e k, input int n, input logic [1:0] m,
                             input int sw_at, input logic [1:0] m2, output int start);
        start = out_q.size();
        mode  = m;
        for (int i = 0; i < n; i++) begin
            if (i == sw_at) mode = m2;
            pixel(pat(k, i), i < HSW);
        end
    endtask

    task automatic check_play(input string tag, input int start, input pat_e k,
                              input int m, input int len, input int last);
        int bad;
        bad = 0;
        for (int j = 2; j <= last; j++) begin
            if (out_q[start + j] !== expect_px(k, j, m, len)) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; base_cen = 1'b0; basex2_cen = 1'b0;
        HS = 1'b0; base_pxl = '0; mode = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_x2_pxl", x2_pxl, 0);
        check("rst_x2_hs",  x2_HS, 0);
        check("rst_ovf",    ovf, 0);
        check("rst_len",    dut.len, HLEN);
        rst_n = 1'b1;

        // Plain doubling of an index ramp
        send_line(PX_INDEX, NPX, 2'd0, -1, 2'd0, st[0]);
        send_line(PX_INDEX, NPX, 2'd0, -1, 2'd0, st[1]);
        send_line(PX_INDEX, NPX, 2'd0, -1, 2'd0, st[2]);
        check_play("mode0_seq", st[2], PX_INDEX, 0, NPX, 2*NPX-1);
        check("mode0_first",       out_q[st[2]+2], 0);
        check("mode0_half0_last",  out_q[st[2]+385], 383);
        check("mode0_half1_first", out_q[st[2]+386], 0);
        cnt = 0;
        for (int j = 0; j < 2*NPX; j++) if (hs_q[st[2]+j]) cnt++;
        check("x2hs_count",     cnt, 2*HSW);
        check("x2hs_start",     hs_q[st[2]+1], 1);
        check("x2hs_end",       hs_q[st[2]+32], 1);
        check("x2hs_off",       hs_q[st[2]+33], 0);
        check("x2hs_half1",     hs_q[st[2]+385], 1);
        check("x2hs_half1_off", hs_q[st[2]+417], 0);

        // Scanline 75 % and 50 %
        send_line(PX_WHITE, NPX, 2'd1, -1, 2'd1, st[3]);
        send_line(PX_WHITE, NPX, 2'd1, -1, 2'd1, st[4]);
        check_play("mode1_seq", st[4], PX_WHITE, 1, NPX, 2*NPX-1);
        check("mode1_half0", out_q[st[4]+12], 12'hFFF);
        check("mode1_half1", out_q[st[4]+400], 12'hCCC);
        send_line(PX_WHITE, NPX, 2'd2, -1, 2'd2, st[5]);
        check_play("mode2_seq", st[5], PX_WHITE, 2, NPX, 2*NPX-1);
        check("mode2_half1", out_q[st[5]+400], 12'h777);

        // Mode change mid-line waits for the next HS rise
        send_line(PX_WHITE, NPX, 2'd0, 100, 2'd2, st[6]);
        check_play("mode_hold_seq", st[6], PX_WHITE, 0, NPX, 2*NPX-1);
        check("mode_hold", out_q[st[6]+600], 12'hFFF);
        send_line(PX_ALT, NPX, 2'd2, -1, 2'd2, st[7]);
        check("mode_switch_applied", out_q[st[7]+600], 12'h777);

        // Horizontal blend
        send_line(PX_ALT, NPX, 2'd3, -1, 2'd3, st[8]);
        check_play("blend_seq", st[8], PX_ALT, 3, NPX, 2*NPX-1);
        check("blend_first", out_q[st[8]+2], 12'h000);
        check("blend_second", out_q[st[8]+3], 12'h777);
        check("blend_third", out_q[st[8]+4], 12'h777);
        check("blend_wrap", out_q[st[8]+386], 12'h000);
        check("ovf_clear", ovf, 0);

        // Overlong line
        send_line(PX_INDEX, 600, 2'd0, -1, 2'd0, st[9]);
        check("ovf_set", ovf, 1);
        send_line(PX_INDEX, 300, 2'd0, -1, 2'd0, st[10]);
        check("len_sat", dut.len, HLEN-1);
        check("cell511", dut.mem[511], 599);
        check_play("ovf_play_seq", st[10], PX_INDEX, 0, HLEN-1, 599);
        check("ovf_play_last", out_q[st[10]+512], 510);
        check("ovf_play_wrap", out_q[st[10]+513], 0);
        check("ovf_sticky", ovf, 1);

        // Asynchronous reset mid-line
        #2 rst_n = 1'b0;
        #1;
        check("midrst_x2_pxl", x2_pxl, 0);
        check("midrst_x2_hs",  x2_HS, 0);
        check("midrst_ovf",    ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_len", dut.len, HLEN);
        send_line(PX_INDEX, NPX, 2'd0, -1, 2'd0, st[11]);
        check("len_first_rise", dut.len, HLEN);
        send_line(PX_INDEX, NPX, 2'd0, -1, 2'd0, st[12]);
        check("len_measured", dut.len, NPX);
        send_line(PX_INDEX, NPX, 2'd0, -1, 2'd0, st[13]);
        check_play("post_rst_seq", st[13], PX_INDEX, 0, NPX, 2*NPX-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
